// File: rtl/dp_bram32_pkg.sv
// dp_bram32_pkg: shared constants for the dual-port block RAM.
//   DP_ADDR_W / DP_DATA_W  default geometry (1024 x 32)
//   DP_INIT_FILL           power-up value of every word
//   DP_INIT_NONE           INIT_FILE value meaning "no file to load"
//   dp_depth()             word count for a given address width
package dp_bram32_pkg;

  localparam int unsigned DP_ADDR_W    = 10;
  localparam int unsigned DP_DATA_W    = 32;
  localparam logic [31:0] DP_INIT_FILL = 32'hDEADBEEF;
  localparam string       DP_INIT_NONE = "NONE";

  function automatic int unsigned dp_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/dp_bram32_if.sv
// dp_bram32_if: bus bundle for both RAM ports.
//   Port A: aa, ena, wea, wda -> rda   (CPU side)
//   Port B: ab, enb, web, wdb -> rdb   (ring side)
//   master: drives address/enable/write, receives read data
//   slave : the RAM itself
interface dp_bram32_if
  import dp_bram32_pkg::*;
#(
  parameter int unsigned ADDR_W = DP_ADDR_W,
  parameter int unsigned DATA_W = DP_DATA_W
);

  logic [ADDR_W-1:0] aa;
  logic              ena;
  logic              wea;
  logic [DATA_W-1:0] wda;
  logic [DATA_W-1:0] rda;

  logic [ADDR_W-1:0] ab;
  logic              enb;
  logic              web;
  logic [DATA_W-1:0] wdb;
  logic [DATA_W-1:0] rdb;

  modport master (
    output aa, ena, wea, wda, ab, enb, web, wdb,
    input  rda, rdb
  );

  modport slave (
    input  aa, ena, wea, wda, ab, enb, web, wdb,
    output rda, rdb
  );

endinterface

// File: rtl/dp_bram32_port.sv
// dp_bram32_port: per-port logic of the dual-port RAM.
//   clock, reset          shared clock, synchronous active-high reset
//   en_i, we_i            port enable / write enable (write needs en_i)
//   addr_i, wdata_i       port address and write data
//   mem_rdata_i           current (pre-edge) word at addr_i from the array
//   mem_we_o, mem_addr_o,
//   mem_wdata_o           gated write request toward the shared array
//   rdata_o               registered read data
// Build option DP_BRAM32_OUTREG_EN adds a second output register (latency 2).
module dp_bram32_port
  import dp_bram32_pkg::*;
#(
  parameter int unsigned ADDR_W = DP_ADDR_W,
  parameter int unsigned DATA_W = DP_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] rd_d, rd_q;

  assign mem_we_o    = en_i & we_i;
  assign mem_addr_o  = addr_i;
  assign mem_wdata_o = wdata_i;

  // Write-first: a write returns its own data; a read returns the pre-edge
  // word, so a same-cycle write from the other port is not yet visible.
  always_comb begin
    rd_d = rd_q;
    if (en_i) begin
      rd_d = we_i ? wdata_i : mem_rdata_i;
    end
  end

  // Reset clears only the output; the write request above is not gated by it.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

`ifdef DP_BRAM32_OUTREG_EN
  logic [DATA_W-1:0] out_d, out_q;

  always_comb begin
    out_d = out_q;
    if (en_i) begin
      out_d = rd_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign rdata_o = out_q;
`else
  assign rdata_o = rd_q;
`endif

endmodule

// File: rtl/dp_bram32.sv
// dp_bram32: true dual-port synchronous RAM, 2**ADDR_W x DATA_W, one clock.
//   clock   rising-edge clock for both ports
//   reset   synchronous active-high; clears read-data registers only
//   bus     dp_bram32_if.slave (port A: aa/ena/wea/wda/rda,
//                               port B: ab/enb/web/wdb/rdb)
// Parameters: ADDR_W, DATA_W, INIT_FILE ("NONE" = no load), INIT_FILL.
// Build option DP_BRAM32_OUTREG_EN: extra output register per port, read
// latency 2 instead of 1; write timing unchanged.
module dp_bram32
  import dp_bram32_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DP_ADDR_W,
  parameter int unsigned       DATA_W    = DP_DATA_W,
  parameter string             INIT_FILE = DP_INIT_NONE,
  parameter logic [DATA_W-1:0] INIT_FILL = DP_INIT_FILL
) (
  input  logic        clock,
  input  logic        reset,
  dp_bram32_if.slave  bus
);

  localparam int unsigned Depth = dp_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [Depth];

  logic              a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic [DATA_W-1:0] a_rdata, b_rdata;

  // Fill so no word ever reads as X.
  initial begin
    for (int unsigned i = 0; i < Depth; i++) begin
      mem_q[i[ADDR_W-1:0]] = INIT_FILL;
    end
  end

  assign a_rdata = mem_q[a_addr];
  assign b_rdata = mem_q[b_addr];

  // Port B is applied last, so it wins a same-address double write.
  always_ff @(posedge clock) begin
    if (a_we) begin
      mem_q[a_addr] <= a_wdata;
    end
    if (b_we) begin
      mem_q[b_addr] <= b_wdata;
    end
  end

  dp_bram32_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_a (
    .clock       (clock),
    .reset       (reset),
    .en_i        (bus.ena),
    .we_i        (bus.wea),
    .addr_i      (bus.aa),
    .wdata_i     (bus.wda),
    .mem_rdata_i (a_rdata),
    .mem_we_o    (a_we),
    .mem_addr_o  (a_addr),
    .mem_wdata_o (a_wdata),
    .rdata_o     (bus.rda)
  );

  dp_bram32_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_b (
    .clock       (clock),
    .reset       (reset),
    .en_i        (bus.enb),
    .we_i        (bus.web),
    .addr_i      (bus.ab),
    .wdata_i     (bus.wdb),
    .mem_rdata_i (b_rdata),
    .mem_we_o    (b_we),
    .mem_addr_o  (b_addr),
    .mem_wdata_o (b_wdata),
    .rdata_o     (bus.rdb)
  );

endmodule

// File: tb/tb_dp_bram32.sv
// tb_dp_bram32: self-checking bench for dp_bram32 (1024 x 32, no init file).
// Expected read data is pushed per port when a read/write is driven and
// popped when its latency has elapsed. Honours DP_BRAM32_OUTREG_EN.
module tb_dp_bram32;
  import dp_bram32_pkg::*;

`ifdef DP_BRAM32_OUTREG_EN
  localparam int unsigned Lat = 2;
`else
  localparam int unsigned Lat = 1;
`endif

  typedef struct {
    logic [31:0] exp;
    int unsigned due;
  } sb_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dp_bram32_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  dp_bram32 #(
    .ADDR_W    (10),
    .DATA_W    (32),
    .INIT_FILE ("NONE"),
    .INIT_FILL (32'hDEADBEEF)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  sb_t         qa[$];
  sb_t         qb[$];
  logic [31:0] mdl [1024];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_errors;
  bit          track;
  logic [31:0] last_a, last_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_due();
    if (qa.size() != 0 && qa[0].due == cyc) begin
      check("rda", bus.rda, qa[0].exp);
      last_a = qa[0].exp;
      void'(qa.pop_front());
    end
    if (qb.size() != 0 && qb[0].due == cyc) begin
      check("rdb", bus.rdb, qb[0].exp);
      last_b = qb[0].exp;
      void'(qb.pop_front());
    end
  endtask

  // One clock: drive both ports, predict, advance, compare whatever is due.
  task automatic step(input logic a_en, input logic a_we, input logic [9:0] a_ad,
                      input logic [31:0] a_wd, input logic b_en, input logic b_we,
                      input logic [9:0] b_ad, input logic [31:0] b_wd);
    logic [31:0] ea, eb;
    bus.ena = a_en; bus.wea = a_we; bus.aa = a_ad; bus.wda = a_wd;
    bus.enb = b_en; bus.web = b_we; bus.ab = b_ad; bus.wdb = b_wd;
    // Reads see the pre-edge model; own writes return their own data.
    ea = a_we ? a_wd : mdl[a_ad];
    eb = b_we ? b_wd : mdl[b_ad];
    if (track && a_en) qa.push_back('{exp: ea, due: cyc + Lat});
    if (track && b_en) qb.push_back('{exp: eb, due: cyc + Lat});
    if (a_en && a_we) mdl[a_ad] = a_wd;
    if (b_en && b_we) mdl[b_ad] = b_wd;
    @(posedge clk);
    cyc++;
    #1;
    check_due();
  endtask

  // Flush outstanding reads with untracked enabled reads, bounded.
  task automatic drain();
    track = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      step(1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd0, 32'd0);
    end
    check("drain", 32'(qa.size() + qb.size()), 32'd0);
    qa.delete();
    qb.delete();
    track = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mdl[i] = 32'hDEADBEEF;
    cyc = 0; n_checks = 0; n_errors = 0; track = 1'b0;
    last_a = '0; last_b = '0;
    bus.ena = 1'b0; bus.wea = 1'b0; bus.aa = '0; bus.wda = '0;
    bus.enb = 1'b0; bus.web = 1'b0; bus.ab = '0; bus.wdb = '0;
    rst = 1'b1;

    // Reset: outputs cleared, but a write presented during reset lands.
    step(1'b1, 1'b1, 10'd20, 32'h0000_2020, 1'b1, 1'b0, 10'd1023, 32'd0);
    check("rst_rda0", bus.rda, 32'd0);
    check("rst_rdb0", bus.rdb, 32'd0);
    step(1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd1023, 32'd0);
    check("rst_rda1", bus.rda, 32'd0);
    check("rst_rdb1", bus.rdb, 32'd0);
    rst = 1'b0;
    track = 1'b1;

    // Fill value at both ends of the address range.
    step(1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd1023, 32'd0);

    // Port A write, write-first echo, then port B read-back.
    step(1'b1, 1'b1, 10'd5, 32'h1234_5678, 1'b1, 1'b0, 10'd0, 32'd0);
    step(1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0);
    drain();

    // Port B burst write, port A reads back in order.
    for (int c = 0; c < 8; c++) begin
      logic [9:0] ad;
      ad = {7'd3, 3'(c)};
      step(1'b1, 1'b0, 10'd1023, 32'd0, 1'b1, 1'b1, ad, 32'(c + 100));
    end
    for (int c = 0; c < 8; c++) begin
      logic [9:0] ad;
      ad = {7'd3, 3'(c)};
      step(1'b1, 1'b0, ad, 32'd0, 1'b1, 1'b0, 10'd0, 32'd0);
    end
    drain();

    // Both ports write address 9: port B data is stored.
    step(1'b1, 1'b1, 10'd9, 32'h0000_000A, 1'b1, 1'b1, 10'd9, 32'h0000_000B);
    step(1'b1, 1'b0, 10'd9, 32'd0, 1'b1, 1'b0, 10'd9, 32'd0);
    drain();

    // A reads 9 while B writes it: A sees the old word, then the new one.
    step(1'b1, 1'b0, 10'd9, 32'd0, 1'b1, 1'b1, 10'd9, 32'h0000_000C);
    step(1'b1, 1'b0, 10'd9, 32'd0, 1'b1, 1'b0, 10'd0, 32'd0);
    // Same rule at the top address with the roles swapped.
    step(1'b1, 1'b1, 10'd1023, 32'h3FF0_3FF0, 1'b1, 1'b0, 10'd1023, 32'd0);
    step(1'b1, 1'b0, 10'd1023, 32'd0, 1'b1, 1'b0, 10'd1023, 32'd0);
    drain();

    // Disabled ports: outputs hold and writes are dropped.
    step(1'b0, 1'b1, 10'd5, 32'hFFFF_FFFF, 1'b0, 1'b1, 10'd6, 32'hEEEE_EEEE);
    check("hold_rda0", bus.rda, last_a);
    check("hold_rdb0", bus.rdb, last_b);
    step(1'b0, 1'b1, 10'd7, 32'h7777_7777, 1'b0, 1'b0, 10'd8, 32'd0);
    check("hold_rda1", bus.rda, last_a);
    check("hold_rdb1", bus.rdb, last_b);
    step(1'b1, 1'b0, 10'd5, 32'd0, 1'b1, 1'b0, 10'd6, 32'd0);
    step(1'b1, 1'b0, 10'd7, 32'd0, 1'b1, 1'b0, 10'd20, 32'd0);
    drain();

    // Random traffic over a small window to provoke collisions.
    for (int i = 0; i < 48; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
           1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
